// File: rtl/usb_port_arbiter.sv
// usb_port_arbiter: shares one usb_hid_host between two USB ports.
// Scans for an attached device, selects it, holds the host in reset while the
// line settles, supervises enumeration and demultiplexes type/report per port.
// Ports:
//   clk12, reset_n            12 MHz clock, synchronous active-low reset
//   line_dp, line_dm [1:0]    raw (asynchronous) line levels per port
//   hid_typ, hid_report,      host type, report strobe and connection error
//   hid_conerr
//   host_rst_n                host reset (usbrst_n)
//   port_sel                  port routed to the host (steers top-level mux)
//   port_active               high while a device is enumerated and active
//   typ0, typ1                latched device type per port
//   report0, report1          per-port report strobes
module usb_port_arbiter #(
    parameter int unsigned SETTLE_CYCLES  = 1200000,
    parameter int unsigned ENUM_TIMEOUT   = 6000000,
    parameter int unsigned DISC_CYCLES    = 30,
    parameter int unsigned BACKOFF_CYCLES = 16
) (
    input  logic       clk12,
    input  logic       reset_n,
    input  logic [1:0] line_dp,
    input  logic [1:0] line_dm,
    input  logic [1:0] hid_typ,
    input  logic       hid_report,
    input  logic       hid_conerr,
    output logic       host_rst_n,
    output logic       port_sel,
    output logic       port_active,
    output logic [1:0] typ0,
    output logic [1:0] typ1,
    output logic       report0,
    output logic       report1
);

    localparam int unsigned TIMER_W = 23;
    localparam int unsigned SE0_W   = $clog2(DISC_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_SCAN,
        ST_SETTLE,
        ST_ENUM,
        ST_ACTIVE,
        ST_BACKOFF
    } state_t;

    logic [1:0]         dp_s1, dp_s2, dm_s1, dm_s2;
    logic [1:0]         present;
    logic [SE0_W-1:0]   se0_cnt [2];
    logic               sel_disc;

    state_t             state, state_d;
    logic               rr, rr_d;
    logic [TIMER_W-1:0] timer, timer_d;
    logic               port_sel_d, host_rst_n_d, port_active_d;
    logic [1:0]         typ0_d, typ1_d;
    logic               report0_d, report1_d;
    logic               typ_we;
    logic [1:0]         typ_val;

    assign present  = dp_s2 | dm_s2;
    assign sel_disc = (se0_cnt[port_sel] == SE0_W'(DISC_CYCLES));

    // Line synchronizers and per-port saturating SE0 counters
    always_ff @(posedge clk12) begin
        if (!reset_n) begin
            dp_s1 <= '0;
            dp_s2 <= '0;
            dm_s1 <= '0;
            dm_s2 <= '0;
            for (int i = 0; i < 2; i++) begin
                se0_cnt[i] <= '0;
            end
        end else begin
            dp_s1 <= line_dp;
            dp_s2 <= dp_s1;
            dm_s1 <= line_dm;
            dm_s2 <= dm_s1;
            for (int i = 0; i < 2; i++) begin
                if (present[i]) begin
                    se0_cnt[i] <= '0;
                end else if (se0_cnt[i] != SE0_W'(DISC_CYCLES)) begin
                    se0_cnt[i] <= se0_cnt[i] + SE0_W'(1);
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk12) begin
        if (!reset_n) begin
            state       <= ST_SCAN;
            rr          <= 1'b0;
            timer       <= '0;
            port_sel    <= 1'b0;
            host_rst_n  <= 1'b0;
            port_active <= 1'b0;
            typ0        <= 2'd0;
            typ1        <= 2'd0;
            report0     <= 1'b0;
            report1     <= 1'b0;
        end else begin
            state       <= state_d;
            rr          <= rr_d;
            timer       <= timer_d;
            port_sel    <= port_sel_d;
            host_rst_n  <= host_rst_n_d;
            port_active <= port_active_d;
            typ0        <= typ0_d;
            typ1        <= typ1_d;
            report0     <= report0_d;
            report1     <= report1_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state;
        rr_d       = rr;
        timer_d    = timer;
        port_sel_d = port_sel;
        typ0_d     = typ0;
        typ1_d     = typ1;
        report0_d  = 1'b0;
        report1_d  = 1'b0;
        typ_we     = 1'b0;
        typ_val    = 2'd0;

        case (state)
            ST_SCAN: begin
                if (present[rr]) begin
                    port_sel_d = rr;
                    timer_d    = '0;
                    state_d    = ST_SETTLE;
                end else begin
                    rr_d = ~rr;
                end
            end
            ST_SETTLE: begin
                timer_d = timer + TIMER_W'(1);
                if (sel_disc) begin
                    state_d = ST_BACKOFF;
                    timer_d = '0;
                    typ_we  = 1'b1;
                end else if (timer == TIMER_W'(SETTLE_CYCLES - 1)) begin
                    state_d = ST_ENUM;
                    timer_d = '0;
                end
            end
            ST_ENUM: begin
                timer_d = timer + TIMER_W'(1);
                // A reported type wins over a same-cycle timeout or error
                if (hid_typ != 2'd0) begin
                    typ_we  = 1'b1;
                    typ_val = hid_typ;
                    state_d = ST_ACTIVE;
                    timer_d = '0;
                end else if (hid_conerr || timer == TIMER_W'(ENUM_TIMEOUT - 1)) begin
                    state_d = ST_BACKOFF;
                    timer_d = '0;
                    typ_we  = 1'b1;
                end
            end
            ST_ACTIVE: begin
                // Leaving ACTIVE drops any report arriving in the same cycle
                if (hid_conerr || hid_typ == 2'd0) begin
                    state_d = ST_BACKOFF;
                    timer_d = '0;
                    typ_we  = 1'b1;
                end else begin
                    typ_we    = 1'b1;
                    typ_val   = hid_typ;
                    report0_d = hid_report & ~port_sel;
                    report1_d = hid_report & port_sel;
                end
            end
            ST_BACKOFF: begin
                timer_d = timer + TIMER_W'(1);
                // Try the other port first on the next scan
                if (timer == TIMER_W'(BACKOFF_CYCLES - 1)) begin
                    state_d = ST_SCAN;
                    timer_d = '0;
                    rr_d    = ~port_sel;
                end
            end
            default: begin
                state_d = ST_SCAN;
                timer_d = '0;
            end
        endcase

        if (typ_we) begin
            if (port_sel) begin
                typ1_d = typ_val;
            end else begin
                typ0_d = typ_val;
            end
        end
    end

    // Registered host controls follow the state being entered
    assign host_rst_n_d  = (state_d == ST_ENUM) || (state_d == ST_ACTIVE);
    assign port_active_d = (state_d == ST_ACTIVE);

endmodule

// File: tb/tb_usb_port_arbiter.sv
// tb_usb_port_arbiter: directed scenarios for usb_port_arbiter with a report
// scoreboard. Small timing parameters keep the run short.
module tb_usb_port_arbiter;

    localparam int unsigned SETTLE  = 100;
    localparam int unsigned ENUM    = 400;
    localparam int unsigned DISC    = 4;
    localparam int unsigned BACKOFF = 16;

    logic       clk12 = 1'b0;
    logic       reset_n;
    logic [1:0] line_dp, line_dm, hid_typ;
    logic       hid_report, hid_conerr;
    logic       host_rst_n, port_sel, port_active;
    logic [1:0] typ0, typ1;
    logic       report0, report1;

    int         total = 0;
    int         bad   = 0;
    logic [1:0] exp_q [$];

    always #5 clk12 = ~clk12;

    usb_port_arbiter #(
        .SETTLE_CYCLES (SETTLE),
        .ENUM_TIMEOUT  (ENUM),
        .DISC_CYCLES   (DISC),
        .BACKOFF_CYCLES(BACKOFF)
    ) dut (
        .clk12      (clk12),
        .reset_n    (reset_n),
        .line_dp    (line_dp),
        .line_dm    (line_dm),
        .hid_typ    (hid_typ),
        .hid_report (hid_report),
        .hid_conerr (hid_conerr),
        .host_rst_n (host_rst_n),
        .port_sel   (port_sel),
        .port_active(port_active),
        .typ0       (typ0),
        .typ1       (typ1),
        .report0    (report0),
        .report1    (report1)
    );

    task automatic tick;
        @(posedge clk12);
        #1;
    endtask

    task automatic apply_reset;
        reset_n    = 1'b0;
        line_dp    = 2'b00;
        line_dm    = 2'b00;
        hid_typ    = 2'd0;
        hid_report = 1'b0;
        hid_conerr = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // Wait for host_rst_n to rise; n = ticks taken
    task automatic wait_release(input int limit, output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (host_rst_n === 1'b1) begin
                ok = 1'b1;
                n  = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        apply_reset();
        total++;
        if ({host_rst_n, port_sel, port_active, typ0, typ1, report0, report1} !== 9'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 000000000",
                     {host_rst_n, port_sel, port_active, typ0, typ1, report0, report1});
        end
        for (int i = 0; i < 10; i++) tick();
        total++;
        if ({host_rst_n, port_active} !== 2'b00) begin
            bad++;
            $display("FAIL idle_no_device: host_rst_n/port_active got %b want 00", {host_rst_n, port_active});
        end
    endtask

    task automatic test_attach_port1;
        int         n;
        bit         ok;
        logic [7:0] pat;
        logic [1:0] exp;
        pat     = 8'b0110_1101;
        line_dp = 2'b10;
        wait_release(SETTLE + 4, n, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL attach1_release: host_rst_n got %b want 1 within %0d cycles", host_rst_n, SETTLE + 4);
        end
        total++;
        if (port_sel !== 1'b1) begin
            bad++;
            $display("FAIL attach1_port_sel: got %b want 1", port_sel);
        end
        hid_typ = 2'd2;
        tick();
        total++;
        if ({typ1, typ0, port_active} !== 5'b10_00_1) begin
            bad++;
            $display("FAIL attach1_active: typ1/typ0/active got %b want 10001", {typ1, typ0, port_active});
        end
        for (int i = 0; i < 8; i++) begin
            hid_report = pat[i];
            exp_q.push_back(pat[i] ? 2'b10 : 2'b00);
            tick();
            exp = exp_q.pop_front();
            total++;
            if ({report1, report0} !== exp) begin
                bad++;
                $display("FAIL attach1_report[%0d]: report1/report0 got %b want %b", i, {report1, report0}, exp);
            end
        end
        hid_report = 1'b0;
        exp_q.push_back(2'b00);
        tick();
        exp = exp_q.pop_front();
        total++;
        if ({report1, report0} !== exp) begin
            bad++;
            $display("FAIL attach1_report_idle: got %b want %b", {report1, report0}, exp);
        end
    endtask

    task automatic test_reset_mid_active;
        reset_n = 1'b0;
        tick();
        total++;
        if ({host_rst_n, port_sel, port_active, typ0, typ1, report0, report1} !== 9'd0) begin
            bad++;
            $display("FAIL reset_mid_active: got %b want 000000000",
                     {host_rst_n, port_sel, port_active, typ0, typ1, report0, report1});
        end
        reset_n = 1'b1;
        line_dp = 2'b00;
        hid_typ = 2'd0;
        for (int i = 0; i < 5; i++) tick();
    endtask

    // SE0 starts before edge a; port_sel=1 is expected after edge a+23:
    // sync 2 + counter 4 + FSM 1 + BACKOFF 16 -> SCAN, then SETTLE 1 more.
    task automatic test_detach_settle;
        bit rose;
        int first;
        rose    = 1'b0;
        first   = -1;
        line_dp = 2'b01;
        for (int i = 0; i < 54; i++) begin
            tick();
            if (host_rst_n === 1'b1) rose = 1'b1;
        end
        line_dp = 2'b00;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 4) line_dp = 2'b11;
            if (host_rst_n === 1'b1) rose = 1'b1;
            if (first < 0 && port_sel === 1'b1) first = i;
        end
        total++;
        if (rose) begin
            bad++;
            $display("FAIL detach_no_release: host_rst_n rose, want stays 0");
        end
        total++;
        if (first != 24) begin
            bad++;
            $display("FAIL detach_backoff_rr: port_sel=1 at tick %0d want 24", first);
        end
        apply_reset();
    endtask

    task automatic test_enum_timeout;
        int n;
        bit ok;
        int hi;
        int k;
        line_dp = 2'b01;
        wait_release(SETTLE + 4, n, ok);
        total++;
        if (!ok || port_sel !== 1'b0) begin
            bad++;
            $display("FAIL timeout_release: ok=%0d port_sel=%b want ok=1 port_sel=0", ok, port_sel);
        end
        hi      = 1;
        line_dp = 2'b11;
        for (int i = 0; i < ENUM + 50; i++) begin
            tick();
            if (host_rst_n === 1'b1) hi++;
            else break;
        end
        total++;
        if (hi != ENUM) begin
            bad++;
            $display("FAIL timeout_len: host_rst_n high %0d cycles want %0d", hi, ENUM);
        end
        k = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (port_sel === 1'b1) begin
                k = i;
                break;
            end
        end
        total++;
        if (k != BACKOFF + 1) begin
            bad++;
            $display("FAIL timeout_next_port: port_sel=1 after %0d cycles want %0d", k, BACKOFF + 1);
        end
        apply_reset();
    endtask

    task automatic test_typ_priority_conerr;
        int         n;
        bit         ok;
        logic [1:0] exp;
        line_dp = 2'b01;
        wait_release(SETTLE + 4, n, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL prio_release: host_rst_n got %b want 1", host_rst_n);
        end
        for (int i = 0; i < ENUM - 1; i++) tick();
        hid_typ = 2'd3;
        tick();
        total++;
        if ({host_rst_n, port_active, typ0} !== 4'b11_11) begin
            bad++;
            $display("FAIL prio_typ_over_timeout: rst/active/typ0 got %b want 1111", {host_rst_n, port_active, typ0});
        end
        hid_typ = 2'd1;
        tick();
        total++;
        if (typ0 !== 2'd1) begin
            bad++;
            $display("FAIL active_typ_track: typ0 got %0d want 1", typ0);
        end
        hid_report = 1'b1;
        exp_q.push_back(2'b01);
        tick();
        hid_report = 1'b0;
        exp = exp_q.pop_front();
        total++;
        if ({report1, report0} !== exp) begin
            bad++;
            $display("FAIL port0_report: got %b want %b", {report1, report0}, exp);
        end
        hid_conerr = 1'b1;
        hid_report = 1'b1;
        exp_q.push_back(2'b00);
        tick();
        hid_conerr = 1'b0;
        hid_report = 1'b0;
        exp = exp_q.pop_front();
        total++;
        if ({report1, report0} !== exp) begin
            bad++;
            $display("FAIL conerr_report_drop: got %b want %b", {report1, report0}, exp);
        end
        total++;
        if ({host_rst_n, port_active, typ0, typ1} !== 6'd0) begin
            bad++;
            $display("FAIL conerr_backoff: rst/active/typ0/typ1 got %b want 000000", {host_rst_n, port_active, typ0, typ1});
        end
        apply_reset();
    endtask

    task automatic test_contention;
        int n;
        bit ok;
        int viol;
        reset_n = 1'b0;
        line_dp = 2'b11;
        hid_typ = 2'd0;
        tick();
        tick();
        reset_n = 1'b1;
        wait_release(SETTLE + 4, n, ok);
        total++;
        if (!ok || port_sel !== 1'b0) begin
            bad++;
            $display("FAIL contention_pick: ok=%0d port_sel=%b want ok=1 port_sel=0", ok, port_sel);
        end
        hid_typ = 2'd2;
        viol    = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            total++;
            if ({port_sel, port_active} !== 2'b01) begin
                bad++;
                viol++;
                if (viol <= 4)
                    $display("FAIL contention_hold[%0d]: sel/active got %b want 01", i, {port_sel, port_active});
            end
        end
        total++;
        if ({typ0, typ1} !== 4'b10_00) begin
            bad++;
            $display("FAIL contention_typ: typ0/typ1 got %b want 1000", {typ0, typ1});
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        line_dp    = 2'b00;
        line_dm    = 2'b00;
        hid_typ    = 2'd0;
        hid_report = 1'b0;
        hid_conerr = 1'b0;
        test_reset();
        test_attach_port1();
        test_reset_mid_active();
        test_detach_settle();
        test_enum_timeout();
        test_typ_priority_conerr();
        test_contention();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
